wt_dcache_rd_ctrl: RTL and testbench



---
 rtl/wt_dcache_rd_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_wt_dcache_rd_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_dcache_rd_ctrl.sv
// Read-port controller for the write-through L1 dcache. It checks each load for a
// hit, hands misses and non-cacheable loads to the miss unit, and replays reads
// that collide with line writes. Replays are bounded; when the bound is reached
// the load goes to memory as a forced non-cacheable access so it always finishes.
// It also keeps saturating hit, miss and replay counters.
//
// state         | meaning
// --------------+----------------------------------------------------------
// IDLE          | no outstanding request, waiting for a grant
// READ          | cache read issued, waiting for the tag to evaluate hit/miss
// MISS_REQ      | miss request presented to the miss unit
// MISS_WAIT     | miss acknowledged, waiting for the return
// REPLAY_REQ    | re-issuing the cache read after a collision
// REPLAY_READ   | evaluating the replayed read with the latched tag
// KILL_MISS_ACK | killed while the miss request was still pending
// KILL_MISS     | killed after the miss ack, draining the return
module wt_dcache_rd_ctrl #(
  parameter int unsigned             CacheIdWidth     = 3,
  parameter logic [CacheIdWidth-1:0] RdTxId           = 1,
  parameter int unsigned             SigWidth         = 14,
  parameter int unsigned             MaxReplays       = 4,
  parameter int unsigned             CntWidth         = 32,
  parameter int unsigned             SetAssoc         = 4,
  parameter int unsigned             IndexWidth       = 12,
  parameter int unsigned             OffsetWidth      = 4,
  parameter int unsigned             TagWidth         = 44,
  parameter logic [63:0]             CachedRegionBase = 64'h0000_0000_8000_0000,
  parameter logic [63:0]             CachedRegionLen  = 64'h0000_0000_4000_0000
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              cache_en_i,
  // core request port
  input  logic                              req_i,
  output logic                              gnt_o,
  input  logic [IndexWidth-1:0]             idx_i,
  input  logic [1:0]                        size_i,
  input  logic                              tag_valid_i,
  input  logic [TagWidth-1:0]               tag_i,
  input  logic [SigWidth-1:0]               sig_i,
  input  logic                              kill_i,
  output logic                              rvalid_o,
  output logic [63:0]                       rdata_o,
  // cache memory read interface
  output logic                              rd_req_o,
  input  logic                              rd_ack_i,
  output logic [TagWidth-1:0]               rd_tag_o,
  output logic [IndexWidth-OffsetWidth-1:0] rd_idx_o,
  output logic [OffsetWidth-1:0]            rd_off_o,
  output logic [SigWidth-1:0]               rd_sig_o,
  input  logic [63:0]                       rd_data_i,
  input  logic [SetAssoc-1:0]               rd_vld_bits_i,
  input  logic [SetAssoc-1:0]               rd_hit_oh_i,
  input  logic                              wr_cl_vld_i,
  input  logic                              conflict_i,
  // miss unit interface
  output logic                              miss_req_o,
  input  logic                              miss_ack_i,
  input  logic                              miss_replay_i,
  input  logic                              miss_rtrn_vld_i,
  output logic [63:0]                       miss_paddr_o,
  output logic                              miss_nc_o,
  output logic                              miss_forced_o,
  output logic [2:0]                        miss_size_o,
  output logic [CacheIdWidth-1:0]           miss_id_o,
  output logic [SigWidth-1:0]               miss_sig_o,
  output logic [SetAssoc-1:0]               miss_vld_bits_o,
  // performance counters
  input  logic                              cnt_clr_i,
  output logic [CntWidth-1:0]               hit_cnt_o,
  output logic [CntWidth-1:0]               miss_cnt_o,
  output logic [CntWidth-1:0]               replay_cnt_o
);

  localparam logic [3:0]  MaxRep          = 4'(MaxReplays);
  localparam logic [63:0] CachedRegionEnd = CachedRegionBase + CachedRegionLen;

  typedef enum logic [2:0] {
    IDLE, READ, MISS_REQ, MISS_WAIT, REPLAY_REQ, REPLAY_READ, KILL_MISS_ACK, KILL_MISS
  } state_e;

  state_e                  state_q, state_d;
  logic [IndexWidth-1:0]   idx_q, idx_d;
  logic [1:0]              size_q, size_d;
  logic [TagWidth-1:0]     tag_q, tag_d;
  logic [SigWidth-1:0]     sig_q, sig_d;
  logic [SetAssoc-1:0]     vld_q, vld_d;
  logic [3:0]              replay_q, replay_d;
  logic                    forced_q, forced_d;
  logic                    rd_ack_q;
  logic [CntWidth-1:0]     hit_cnt_q, miss_cnt_q, replay_cnt_q;
  logic                    hit_inc, miss_inc, replay_inc;
  logic [63:0]             paddr_q, paddr_chk;
  logic                    nc_chk, collision;

  // The hit check uses the tag arriving this cycle (or the latched one on a replay).
  assign paddr_q   = 64'({tag_q, idx_q});
  assign paddr_chk = 64'({tag_d, idx_q});
  assign nc_chk    = forced_q | ~cache_en_i |
                     ~((paddr_chk >= CachedRegionBase) && (paddr_chk < CachedRegionEnd));
  assign collision = wr_cl_vld_i | conflict_i | ~rd_ack_q;

  assign rd_tag_o  = tag_d;
  assign rd_idx_o  = idx_d[IndexWidth-1:OffsetWidth];
  assign rd_off_o  = idx_d[OffsetWidth-1:0];
  assign rd_sig_o  = sig_d;
  assign rdata_o   = rd_data_i;

  assign miss_paddr_o    = paddr_q;
  assign miss_nc_o       = forced_q | ~cache_en_i |
                           ~((paddr_q >= CachedRegionBase) && (paddr_q < CachedRegionEnd));
  assign miss_forced_o   = forced_q;
  assign miss_size_o     = miss_nc_o ? {1'b0, size_q} : 3'b111;
  assign miss_id_o       = RdTxId;
  assign miss_sig_o      = sig_q;
  assign miss_vld_bits_o = vld_q;

  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;
  assign replay_cnt_o = replay_cnt_q;

  // Next-state, handshake outputs and request-register updates.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    size_d     = size_q;
    tag_d      = tag_q;
    sig_d      = sig_q;
    vld_d      = vld_q;
    replay_d   = replay_q;
    forced_d   = forced_q;
    gnt_o      = 1'b0;
    rvalid_o   = 1'b0;
    rd_req_o   = 1'b0;
    miss_req_o = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    replay_inc = 1'b0;

    if (state_q == READ && tag_valid_i) begin
      tag_d = tag_i;
      sig_d = sig_i;
    end

    unique case (state_q)
      IDLE: begin
        rd_req_o = req_i;
        if (req_i && rd_ack_i) begin
          gnt_o   = 1'b1;
          state_d = READ;
        end
      end
      READ, REPLAY_READ: begin
        rd_req_o = 1'b1;
        if (kill_i) begin
          rvalid_o = 1'b1;
          state_d  = IDLE;
        end else if (tag_valid_i || state_q == REPLAY_READ) begin
          vld_d = rd_vld_bits_i;
          if (collision) begin
            if (replay_q < MaxRep) begin
              replay_d   = replay_q + 4'd1;
              replay_inc = 1'b1;
              state_d    = REPLAY_REQ;
            end else begin
              forced_d = 1'b1;
              state_d  = MISS_REQ;
            end
          end else if ((|rd_hit_oh_i) && !nc_chk) begin
            rvalid_o = 1'b1;
            hit_inc  = 1'b1;
            state_d  = IDLE;
            if (req_i && rd_ack_i) begin
              gnt_o   = 1'b1;
              state_d = READ;
            end
          end else begin
            miss_inc = 1'b1;
            state_d  = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        miss_req_o = 1'b1;
        if (kill_i) begin
          rvalid_o = 1'b1;
          state_d  = miss_ack_i ? KILL_MISS : KILL_MISS_ACK;
        end else if (miss_replay_i) begin
          state_d = REPLAY_REQ;
        end else if (miss_ack_i) begin
          state_d = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (miss_rtrn_vld_i) begin
          rvalid_o = 1'b1;
          state_d  = IDLE;
        end else if (kill_i) begin
          rvalid_o = 1'b1;
          state_d  = KILL_MISS;
        end
      end
      REPLAY_REQ: begin
        rd_req_o = 1'b1;
        if (kill_i) begin
          rvalid_o = 1'b1;
          state_d  = IDLE;
        end else if (rd_ack_i) begin
          state_d = REPLAY_READ;
        end
      end
      KILL_MISS_ACK: begin
        miss_req_o = 1'b1;
        if (miss_replay_i) begin
          state_d = IDLE;
        end else if (miss_ack_i) begin
          state_d = KILL_MISS;
        end
      end
      KILL_MISS: begin
        if (miss_rtrn_vld_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new request starts with a fresh replay budget.
    if (gnt_o) begin
      idx_d    = idx_i;
      size_d   = size_i;
      replay_d = 4'd0;
      forced_d = 1'b0;
    end
  end

  // State and request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      size_q   <= '0;
      tag_q    <= '0;
      sig_q    <= '0;
      vld_q    <= '0;
      replay_q <= '0;
      forced_q <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      size_q   <= size_d;
      tag_q    <= tag_d;
      sig_q    <= sig_d;
      vld_q    <= vld_d;
      replay_q <= replay_d;
      forced_q <= forced_d;
      rd_ack_q <= rd_ack_i;
    end
  end

  // Saturating performance counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      replay_cnt_q <= '0;
    end else if (cnt_clr_i) begin
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      replay_cnt_q <= '0;
    end else begin
      if (hit_inc && hit_cnt_q != '1)       hit_cnt_q    <= hit_cnt_q + 1'b1;
      if (miss_inc && miss_cnt_q != '1)     miss_cnt_q   <= miss_cnt_q + 1'b1;
      if (replay_inc && replay_cnt_q != '1) replay_cnt_q <= replay_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_wt_dcache_rd_ctrl.sv
// Directed bench for wt_dcache_rd_ctrl. A second instance with 2-bit counters
// shares all stimulus so counter saturation can be observed.
module tb_wt_dcache_rd_ctrl;

  logic        clk, rst, cache_en, req, kill, tag_valid;
  logic        gnt, rvalid, rd_req, rd_ack, wr_cl, conflict;
  logic        miss_req, miss_ack, miss_replay, rtrn, miss_nc, miss_forced, cnt_clr;
  logic [11:0] idx;
  logic [1:0]  size;
  logic [43:0] tag, rd_tag;
  logic [13:0] sig, rd_sig, miss_sig;
  logic [63:0] rdata, rd_data, miss_paddr;
  logic [7:0]  rd_idx;
  logic [3:0]  rd_off, rd_vld, hit_oh, miss_vld;
  logic [2:0]  miss_size, miss_id;
  logic [31:0] hit_cnt, miss_cnt, replay_cnt;

  logic        gnt2, rvalid2, rd_req2, miss_req2, miss_nc2, miss_forced2;
  logic [63:0] rdata2, miss_paddr2;
  logic [43:0] rd_tag2;
  logic [7:0]  rd_idx2;
  logic [3:0]  rd_off2, miss_vld2;
  logic [13:0] rd_sig2, miss_sig2;
  logic [2:0]  miss_size2, miss_id2;
  logic [1:0]  hit_cnt2, miss_cnt2, replay_cnt2;

  int n_vec, n_err;

  wt_dcache_rd_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .cache_en_i(cache_en), .req_i(req), .gnt_o(gnt),
    .idx_i(idx), .size_i(size), .tag_valid_i(tag_valid), .tag_i(tag), .sig_i(sig),
    .kill_i(kill), .rvalid_o(rvalid), .rdata_o(rdata), .rd_req_o(rd_req), .rd_ack_i(rd_ack),
    .rd_tag_o(rd_tag), .rd_idx_o(rd_idx), .rd_off_o(rd_off), .rd_sig_o(rd_sig),
    .rd_data_i(rd_data), .rd_vld_bits_i(rd_vld), .rd_hit_oh_i(hit_oh),
    .wr_cl_vld_i(wr_cl), .conflict_i(conflict), .miss_req_o(miss_req), .miss_ack_i(miss_ack),
    .miss_replay_i(miss_replay), .miss_rtrn_vld_i(rtrn), .miss_paddr_o(miss_paddr),
    .miss_nc_o(miss_nc), .miss_forced_o(miss_forced), .miss_size_o(miss_size),
    .miss_id_o(miss_id), .miss_sig_o(miss_sig), .miss_vld_bits_o(miss_vld),
    .cnt_clr_i(cnt_clr), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt), .replay_cnt_o(replay_cnt)
  );

  wt_dcache_rd_ctrl #(.CntWidth(2)) u_dut_sat (
    .clk_i(clk), .rst_i(rst), .cache_en_i(cache_en), .req_i(req), .gnt_o(gnt2),
    .idx_i(idx), .size_i(size), .tag_valid_i(tag_valid), .tag_i(tag), .sig_i(sig),
    .kill_i(kill), .rvalid_o(rvalid2), .rdata_o(rdata2), .rd_req_o(rd_req2), .rd_ack_i(rd_ack),
    .rd_tag_o(rd_tag2), .rd_idx_o(rd_idx2), .rd_off_o(rd_off2), .rd_sig_o(rd_sig2),
    .rd_data_i(rd_data), .rd_vld_bits_i(rd_vld), .rd_hit_oh_i(hit_oh),
    .wr_cl_vld_i(wr_cl), .conflict_i(conflict), .miss_req_o(miss_req2), .miss_ack_i(miss_ack),
    .miss_replay_i(miss_replay), .miss_rtrn_vld_i(rtrn), .miss_paddr_o(miss_paddr2),
    .miss_nc_o(miss_nc2), .miss_forced_o(miss_forced2), .miss_size_o(miss_size2),
    .miss_id_o(miss_id2), .miss_sig_o(miss_sig2), .miss_vld_bits_o(miss_vld2),
    .cnt_clr_i(cnt_clr), .hit_cnt_o(hit_cnt2), .miss_cnt_o(miss_cnt2), .replay_cnt_o(replay_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag_s, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag_s, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    req = 1'b0; kill = 1'b0; tag_valid = 1'b0; wr_cl = 1'b0; conflict = 1'b0;
    miss_ack = 1'b0; miss_replay = 1'b0; rtrn = 1'b0; rd_ack = 1'b1; hit_oh = '0;
    cache_en = 1'b1; cnt_clr = 1'b0; rd_vld = '0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    quiet();
    rst = 1'b1; idx = '0; size = '0; tag = '0; sig = '0; rd_data = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_miss_req", miss_req, 0);
    chk("rst_forced", miss_forced, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_replay_cnt", replay_cnt, 0);
    rst = 1'b0;
    tick();

    // single hit
    req = 1'b1; idx = 12'h040; size = 2'b11; #1;
    chk("hit_gnt", gnt, 1);
    chk("hit_rd_req", rd_req, 1);
    chk("hit_rd_idx", rd_idx, 8'h04);
    tick();
    req = 1'b0; tag_valid = 1'b1; tag = 44'h80000; sig = 14'h0aa; hit_oh = 4'b0001;
    rd_data = 64'hdead_beef_0123_4567; #1;
    chk("hit_rvalid", rvalid, 1);
    chk("hit_rdata", rdata, 64'hdead_beef_0123_4567);
    tick(); quiet(); #1;
    chk("hit_rvalid_once", rvalid, 0);
    chk("hit_cnt_1", hit_cnt, 1);

    // cacheable miss
    req = 1'b1; idx = 12'h080; size = 2'b10; #1;
    chk("miss_gnt", gnt, 1);
    tick();
    req = 1'b0; tag_valid = 1'b1; tag = 44'h80001; sig = 14'h1234; hit_oh = '0; rd_vld = 4'b1010; #1;
    chk("miss_no_rvalid", rvalid, 0);
    tick(); quiet(); #1;
    chk("miss_req", miss_req, 1);
    chk("miss_size", miss_size, 3'b111);
    chk("miss_nc", miss_nc, 0);
    chk("miss_paddr", miss_paddr, 64'h8000_1080);
    chk("miss_vld", miss_vld, 4'b1010);
    chk("miss_sig", miss_sig, 14'h1234);
    chk("miss_id", miss_id, 1);
    chk("miss_cnt_1", miss_cnt, 1);
    miss_ack = 1'b1;
    tick(); quiet(); #1;
    chk("miss_wait_req", miss_req, 0);
    chk("miss_wait_rvalid", rvalid, 0);
    tick(); rtrn = 1'b1; #1;
    chk("miss_rtrn_rvalid", rvalid, 1);
    tick(); quiet(); #1;
    chk("miss_rvalid_once", rvalid, 0);

    // hit tags outside the cacheable region become non-cacheable misses
    req = 1'b1; idx = 12'h040; size = 2'b10;
    tick();
    req = 1'b0; tag_valid = 1'b1; tag = 44'h00010; hit_oh = 4'b0001; #1;
    chk("nc_no_hit", rvalid, 0);
    tick(); quiet(); #1;
    chk("nc_miss_nc", miss_nc, 1);
    chk("nc_size", miss_size, 3'b010);
    chk("nc_forced", miss_forced, 0);
    chk("nc_paddr", miss_paddr, 64'h0001_0040);
    miss_ack = 1'b1;
    tick(); quiet();
    tick(); rtrn = 1'b1; #1;
    chk("nc_rvalid", rvalid, 1);
    tick(); quiet();

    // replay exhaustion with the line write held
    req = 1'b1; idx = 12'h0c0; size = 2'b01; wr_cl = 1'b1;
    tick();
    req = 1'b0; tag_valid = 1'b1; tag = 44'h80002; hit_oh = 4'b0001; #1;
    chk("rpl_first_no_rvalid", rvalid, 0);
    tick();
    tag_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rpl_rd_req", rd_req, 1);
      chk("rpl_no_miss_req", miss_req, 0);
      tick();
      #1;
      chk("rpl_read_no_rvalid", rvalid, 0);
      tick();
    end
    #1;
    chk("rpl_miss_req", miss_req, 1);
    chk("rpl_nc", miss_nc, 1);
    chk("rpl_forced", miss_forced, 1);
    chk("rpl_size", miss_size, 3'b001);
    chk("rpl_replay_cnt", replay_cnt, 4);
    chk("rpl_miss_cnt", miss_cnt, 2);
    wr_cl = 1'b0; miss_ack = 1'b1;
    tick(); quiet();
    tick(); rtrn = 1'b1; #1;
    chk("rpl_rvalid", rvalid, 1);
    tick(); quiet();

    // kill in MISS_REQ before ack, then miss unit replays the dropped request
    req = 1'b1; idx = 12'h100; size = 2'b11; #1;
    chk("kill_gnt", gnt, 1);
    tick();
    req = 1'b0; tag_valid = 1'b1; tag = 44'h80003; hit_oh = '0;
    tick(); quiet(); #1;
    chk("kill_miss_req", miss_req, 1);
    chk("kill_forced_clr", miss_forced, 0);
    kill = 1'b1; #1;
    chk("kill_rvalid", rvalid, 1);
    tick(); kill = 1'b0; #1;
    chk("kill_ack_pending_req", miss_req, 1);
    chk("kill_ack_pending_rvalid", rvalid, 0);
    miss_replay = 1'b1;
    tick(); quiet(); #1;
    chk("kill_idle_miss_req", miss_req, 0);
    rtrn = 1'b1; #1;
    chk("kill_late_rtrn", rvalid, 0);
    tick(); quiet();

    // clear, then four hits with three back-to-back grants
    cnt_clr = 1'b1;
    tick(); cnt_clr = 1'b0; #1;
    chk("clr_hit_cnt", hit_cnt, 0);
    chk("clr_replay_cnt", replay_cnt, 0);
    req = 1'b1; idx = 12'h200; #1;
    chk("b2b_gnt0", gnt, 1);
    tick();
    for (int j = 0; j < 3; j++) begin
      req = 1'b1; idx = 12'(12'h210 + j * 16); tag_valid = 1'b1; tag = 44'h80004;
      hit_oh = 4'b0010; rd_data = 64'(64'h100 + j); #1;
      chk("b2b_gnt", gnt, 1);
      chk("b2b_rvalid", rvalid, 1);
      chk("b2b_rdata", rdata, 64'(64'h100 + j));
      tick();
    end
    req = 1'b0; tag_valid = 1'b1; hit_oh = 4'b0010; #1;
    chk("b2b_last_rvalid", rvalid, 1);
    chk("b2b_last_gnt", gnt, 0);
    tick(); quiet(); #1;
    chk("b2b_hit_cnt", hit_cnt, 4);
    chk("sat_hit_cnt", hit_cnt2, 3);

    // clear wins over a same-cycle hit increment
    req = 1'b1; idx = 12'h040;
    tick();
    req = 1'b0; tag_valid = 1'b1; tag = 44'h80000; hit_oh = 4'b0001; cnt_clr = 1'b1; #1;
    chk("clrpri_rvalid", rvalid, 1);
    tick(); quiet(); #1;
    chk("clrpri_hit_cnt", hit_cnt, 0);

    // reset while waiting for a miss return
    req = 1'b1; idx = 12'h080;
    tick();
    req = 1'b0; tag_valid = 1'b1; tag = 44'h80001; hit_oh = '0;
    tick(); quiet(); miss_ack = 1'b1; #1;
    chk("rstmw_miss_req", miss_req, 1);
    tick(); quiet(); #1;
    chk("rstmw_miss_cnt", miss_cnt, 1);
    rst = 1'b1; #1;
    chk("rstmw_miss_req0", miss_req, 0);
    chk("rstmw_rvalid0", rvalid, 0);
    chk("rstmw_rd_req0", rd_req, 0);
    chk("rstmw_miss_cnt0", miss_cnt, 0);
    tick(); rst = 1'b0;
    tick(); rtrn = 1'b1; #1;
    chk("rstmw_stale_rtrn", rvalid, 0);
    tick(); quiet();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
